// File: rtl/cpi_pkg.sv
// Shared CPI request-layer types: connection state, request beat and parity helper.
package cpi_pkg;

    localparam int CPI_REQ_HDR_W = 129;
    localparam int CPI_PID_W     = 4;

    typedef enum logic [1:0] {
        CONN_DISCON        = 2'd0,
        CONN_CONNECTING    = 2'd1,
        CONN_CONNECTED     = 2'd2,
        CONN_DISCONNECTING = 2'd3
    } cpi_conn_state_e;

    typedef struct packed {
        logic [CPI_PID_W-1:0]     protocol_id;
        logic [CPI_REQ_HDR_W-1:0] header;
    } cpi_req_t;

    function automatic logic cpi_req_parity(input cpi_req_t req);
        return ^req;
    endfunction

endpackage

// File: rtl/cpi_sync_fifo.sv
// Single-clock FIFO with power-of-two depth; pointers wrap naturally, count has one extra bit.
module cpi_sync_fifo
    import cpi_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = cpi_req_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  T                       wdata,
    input  logic                   pop,
    output T                       rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW-1:0]  rptr_q, rptr_d;
    logic [AW:0]    count_q, count_d;

    // Next pointer and occupancy values.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end else begin
            rptr_d = rptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= AW'(0);
            rptr_q  <= AW'(0);
            count_q <= (AW+1)'(0);
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage write port; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rptr_q];
    assign count = count_q;

endmodule

// File: rtl/cpi_a2f_req_tx.sv
// Agent-side CPI request transmitter: connect FSM, request FIFO and credit-metered issue.
// Optional CPI_REQ_PARITY_EN adds a registered a2f_req_parity output.
module cpi_a2f_req_tx
    import cpi_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int CREDITS = 4
) (
    input  logic                       fm_clk,
    input  logic                       fm_rst,
    input  logic                       link_up_req,
    input  logic                       link_down_req,
    output logic                       a2f_txcon_req,
    input  logic                       a2f_rxcon_ack,
    input  logic                       a2f_rxdiscon_nack,
    input  logic                       req_push_valid,
    output logic                       req_push_ready,
    input  logic [CPI_PID_W-1:0]       req_push_protocol_id,
    input  logic [CPI_REQ_HDR_W-1:0]   req_push_header,
    output logic                       a2f_req_is_valid,
    output logic [CPI_PID_W-1:0]       a2f_req_protocol_id,
    output logic [CPI_REQ_HDR_W-1:0]   a2f_req_header,
    input  logic                       f2a_req_crd_rtn,
    output logic [1:0]                 conn_state,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       err_crd_overflow
`ifdef CPI_REQ_PARITY_EN
    ,
    output logic                       a2f_req_parity
`endif
);

    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam int              KW      = $clog2(CREDITS + 1);
    localparam logic [KW-1:0]   CRD_MAX = KW'(CREDITS);

    cpi_conn_state_e state_q, state_d;
    logic            txcon_q, txcon_d;
    logic [KW-1:0]   crd_q, crd_d;
    logic            err_q, err_d;
    logic            vld_q, vld_d;
    cpi_req_t        beat_q, beat_d;
    cpi_req_t        push_req_s, head_s;
    logic [CW-1:0]   count_s;
    logic            push_s, issue_s, load_s, clear_s;

    cpi_sync_fifo #(
        .DEPTH (DEPTH),
        .T     (cpi_req_t)
    ) u_fifo (
        .clk   (fm_clk),
        .rst_n (fm_rst),
        .push  (push_s),
        .wdata (push_req_s),
        .pop   (issue_s),
        .rdata (head_s),
        .count (count_s)
    );

    // Handshake FSM, issue decision and credit accounting.
    always_comb begin
        push_req_s = '{protocol_id: req_push_protocol_id, header: req_push_header};
        push_s     = req_push_valid && req_push_ready;
        issue_s    = (state_q == CONN_CONNECTED) && (count_s != CW'(0)) && (crd_q != KW'(0));
        state_d    = state_q;
        load_s     = 1'b0;
        clear_s    = 1'b0;

        case (state_q)
            CONN_DISCON: begin
                if (link_up_req) state_d = CONN_CONNECTING;
                else             state_d = CONN_DISCON;
            end
            CONN_CONNECTING: begin
                if (a2f_rxcon_ack) begin
                    state_d = CONN_CONNECTED;
                    load_s  = 1'b1;
                end else if (!link_up_req) begin
                    state_d = CONN_DISCON;
                end else begin
                    state_d = CONN_CONNECTING;
                end
            end
            CONN_CONNECTED: begin
                if (link_down_req) state_d = CONN_DISCONNECTING;
                else               state_d = CONN_CONNECTED;
            end
            CONN_DISCONNECTING: begin
                // Nack wins over a simultaneous ack drop.
                if (a2f_rxdiscon_nack) begin
                    state_d = CONN_CONNECTED;
                end else if (!a2f_rxcon_ack) begin
                    state_d = CONN_DISCON;
                    clear_s = 1'b1;
                end else begin
                    state_d = CONN_DISCONNECTING;
                end
            end
            default: state_d = CONN_DISCON;
        endcase

        txcon_d = (state_d == CONN_CONNECTING) || (state_d == CONN_CONNECTED);
        err_d   = err_q | (f2a_req_crd_rtn && !issue_s && (crd_q == CRD_MAX));

        crd_d = crd_q;
        if (load_s) begin
            crd_d = CRD_MAX;
        end else if (clear_s) begin
            crd_d = KW'(0);
        end else if (issue_s && !f2a_req_crd_rtn) begin
            crd_d = crd_q - KW'(1);
        end else if (!issue_s && f2a_req_crd_rtn && (crd_q != CRD_MAX)) begin
            crd_d = crd_q + KW'(1);
        end else begin
            crd_d = crd_q;
        end

        vld_d = issue_s;
        if (issue_s) beat_d = head_s;
        else         beat_d = beat_q;
    end

    // State, credit, error and output-beat registers.
    always_ff @(posedge fm_clk or negedge fm_rst) begin
        if (!fm_rst) begin
            state_q <= CONN_DISCON;
            txcon_q <= 1'b0;
            crd_q   <= KW'(0);
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            txcon_q <= txcon_d;
            crd_q   <= crd_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            beat_q  <= beat_d;
        end
    end

    assign req_push_ready      = (count_s < CW'(DEPTH));
    assign a2f_txcon_req       = txcon_q;
    assign a2f_req_is_valid    = vld_q;
    assign a2f_req_protocol_id = beat_q.protocol_id;
    assign a2f_req_header      = beat_q.header;
    assign conn_state          = state_q;
    assign fifo_count          = count_s;
    assign err_crd_overflow    = err_q;

`ifdef CPI_REQ_PARITY_EN
    logic parity_q, parity_d;

    // Parity travels with the beat and holds with it when idle.
    always_comb begin
        if (issue_s) parity_d = cpi_req_parity(head_s);
        else         parity_d = parity_q;
    end

    // Parity register.
    always_ff @(posedge fm_clk or negedge fm_rst) begin
        if (!fm_rst) parity_q <= 1'b0;
        else         parity_q <= parity_d;
    end

    assign a2f_req_parity = parity_q;
`endif

endmodule

// File: tb/tb_cpi_a2f_req_tx.sv
// Self-checking bench for cpi_a2f_req_tx: directed scenarios plus randomized traffic vs a queue model.
module tb_cpi_a2f_req_tx;
    import cpi_pkg::*;

    localparam int DEPTH   = 8;
    localparam int CREDITS = 4;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic                     fm_clk, fm_rst;
    logic                     link_up_req, link_down_req, a2f_txcon_req;
    logic                     a2f_rxcon_ack, a2f_rxdiscon_nack;
    logic                     req_push_valid, req_push_ready;
    logic [CPI_PID_W-1:0]     req_push_protocol_id, a2f_req_protocol_id;
    logic [CPI_REQ_HDR_W-1:0] req_push_header, a2f_req_header;
    logic                     a2f_req_is_valid, f2a_req_crd_rtn;
    logic [1:0]               conn_state;
    logic [CW-1:0]            fifo_count;
    logic                     err_crd_overflow;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state
    int       m_state, m_cred;
    bit       m_err, m_valid;
    cpi_req_t m_q[$];
    cpi_req_t m_out;
    // Expected issue order for directed scenarios
    cpi_req_t pend[$];

    cpi_a2f_req_tx #(.DEPTH(DEPTH), .CREDITS(CREDITS)) dut (
        .fm_clk(fm_clk), .fm_rst(fm_rst),
        .link_up_req(link_up_req), .link_down_req(link_down_req),
        .a2f_txcon_req(a2f_txcon_req), .a2f_rxcon_ack(a2f_rxcon_ack),
        .a2f_rxdiscon_nack(a2f_rxdiscon_nack),
        .req_push_valid(req_push_valid), .req_push_ready(req_push_ready),
        .req_push_protocol_id(req_push_protocol_id), .req_push_header(req_push_header),
        .a2f_req_is_valid(a2f_req_is_valid), .a2f_req_protocol_id(a2f_req_protocol_id),
        .a2f_req_header(a2f_req_header), .f2a_req_crd_rtn(f2a_req_crd_rtn),
        .conn_state(conn_state), .fifo_count(fifo_count),
        .err_crd_overflow(err_crd_overflow)
    );

    initial fm_clk = 1'b0;
    always #5 fm_clk = ~fm_clk;

    function automatic cpi_req_t cur_req();
        return '{protocol_id: req_push_protocol_id, header: req_push_header};
    endfunction

    function automatic cpi_req_t dut_beat();
        return '{protocol_id: a2f_req_protocol_id, header: a2f_req_header};
    endfunction

    task automatic model_reset();
        m_state = 0; m_cred = 0; m_err = 0; m_valid = 0; m_out = '0;
        m_q.delete();
    endtask

    // One clock of the protocol rules, using the inputs sampled at this edge.
    task automatic model_step();
        bit push, issue;
        push  = req_push_valid && (m_q.size() < DEPTH);
        issue = (m_state == 2) && (m_q.size() != 0) && (m_cred > 0);
        m_valid = issue;
        if (issue) m_out = m_q.pop_front();
        if (issue && !f2a_req_crd_rtn) m_cred = m_cred - 1;
        else if (!issue && f2a_req_crd_rtn) begin
            if (m_cred == CREDITS) m_err = 1;
            else m_cred = m_cred + 1;
        end
        case (m_state)
            0: if (link_up_req) m_state = 1;
            1: if (a2f_rxcon_ack) begin m_state = 2; m_cred = CREDITS; end
               else if (!link_up_req) m_state = 0;
            2: if (link_down_req) m_state = 3;
            3: if (a2f_rxdiscon_nack) m_state = 2;
               else if (!a2f_rxcon_ack) begin m_state = 0; m_cred = 0; end
            default: m_state = 0;
        endcase
        if (push) m_q.push_back(cur_req());
    endtask

    task automatic tick();
        @(posedge fm_clk);
        model_step();
        @(negedge fm_clk);
    endtask

    task automatic drive_push(input bit v);
        req_push_valid       = v;
        req_push_protocol_id = 4'($urandom());
        req_push_header      = {$urandom(), $urandom(), $urandom(), $urandom(), 1'($urandom())};
    endtask

    task automatic test_reset();
        #2;
        fm_rst = 1'b0;
        link_up_req = 0; link_down_req = 0; a2f_rxcon_ack = 0; a2f_rxdiscon_nack = 0;
        f2a_req_crd_rtn = 0; drive_push(1'b0);
        model_reset();
        pend.delete();
        #1;
        n_cmp++; if (conn_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", conn_state); end
        n_cmp++; if (a2f_txcon_req !== 1'b0) begin n_fail++; $display("FAIL reset_txcon: got %b want 0", a2f_txcon_req); end
        n_cmp++; if (a2f_req_is_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", a2f_req_is_valid); end
        n_cmp++; if (a2f_req_protocol_id !== 4'd0) begin n_fail++; $display("FAIL reset_pid: got %h want 0", a2f_req_protocol_id); end
        n_cmp++; if (a2f_req_header !== 129'd0) begin n_fail++; $display("FAIL reset_header: got %h want 0", a2f_req_header); end
        n_cmp++; if (fifo_count !== CW'(0)) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_cmp++; if (req_push_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_push_ready); end
        n_cmp++; if (err_crd_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_crd_overflow); end
        @(negedge fm_clk);
        @(negedge fm_clk);
        fm_rst = 1'b1;
    endtask

    task automatic test_connect();
        link_up_req = 1;
        tick();
        n_cmp++; if ({conn_state, a2f_txcon_req, a2f_req_is_valid} !== 4'b01_1_0) begin
            n_fail++; $display("FAIL connect_enter: state/txcon/valid got %b want 0110", {conn_state, a2f_txcon_req, a2f_req_is_valid}); end
        tick(); tick();
        n_cmp++; if (conn_state !== 2'd1) begin n_fail++; $display("FAIL connect_wait: got %0d want 1", conn_state); end
        a2f_rxcon_ack = 1;
        tick();
        n_cmp++; if ({conn_state, a2f_txcon_req, a2f_req_is_valid} !== 4'b10_1_0) begin
            n_fail++; $display("FAIL connect_ack: state/txcon/valid got %b want 1010", {conn_state, a2f_txcon_req, a2f_req_is_valid}); end
    endtask

    // Pushes n requests then idles; expects exactly exp_issue ordered issues and a residue count.
    task automatic burst_push(input string tag, input int n, input int exp_issue, input int exp_left);
        int np = 0;
        for (int i = 0; i < n + 8; i++) begin
            drive_push(i < n);
            if (i < n) pend.push_back(cur_req());
            tick();
            if (a2f_req_is_valid === 1'b1) begin
                np++;
                n_cmp++;
                if (pend.size() == 0 || dut_beat() !== pend[0]) begin
                    n_fail++; $display("FAIL %s_order: issue %0d got %h", tag, np, dut_beat()); end
                if (pend.size() != 0) void'(pend.pop_front());
            end
        end
        drive_push(1'b0);
        n_cmp++; if (np != exp_issue) begin n_fail++; $display("FAIL %s_issues: got %0d want %0d", tag, np, exp_issue); end
        n_cmp++; if (fifo_count !== CW'(exp_left)) begin n_fail++; $display("FAIL %s_count: got %0d want %0d", tag, fifo_count, exp_left); end
    endtask

    task automatic test_full_fifo();
        for (int i = 0; i < 9; i++) begin
            drive_push(1'b1);
            if (i < 8) pend.push_back(cur_req());
            tick();
            n_cmp++; if (fifo_count !== CW'((i < 8) ? i + 1 : 8)) begin
                n_fail++; $display("FAIL full_count: push %0d got %0d", i, fifo_count); end
            n_cmp++; if (req_push_ready !== ((i + 1) < 8)) begin
                n_fail++; $display("FAIL full_ready: push %0d got %b", i, req_push_ready); end
        end
        drive_push(1'b0);
        test_connect();
        burst_push("full", 0, 4, 4);
    endtask

    task automatic test_credit_stall();
        burst_push("stall", 6, 4, 2);
        f2a_req_crd_rtn = 1;
        tick();
        n_cmp++; if (a2f_req_is_valid !== 1'b0) begin n_fail++; $display("FAIL stall_rtn_edge: got %b want 0", a2f_req_is_valid); end
        f2a_req_crd_rtn = 0;
        tick();
        n_cmp++; if (a2f_req_is_valid !== 1'b1 || dut_beat() !== pend[0]) begin
            n_fail++; $display("FAIL stall_fifth: valid %b beat %h", a2f_req_is_valid, dut_beat()); end
        void'(pend.pop_front());
        tick();
        n_cmp++; if ({a2f_req_is_valid, fifo_count} !== {1'b0, CW'(1)}) begin
            n_fail++; $display("FAIL stall_after: valid/count got %b want 0/1", {a2f_req_is_valid, fifo_count}); end
    endtask

    task automatic test_simul_issue_return();
        for (int i = 0; i < 2; i++) begin
            drive_push(1'b1); pend.push_back(cur_req()); tick();
        end
        drive_push(1'b0);
        f2a_req_crd_rtn = 1;
        tick();
        n_cmp++; if (a2f_req_is_valid !== 1'b0) begin n_fail++; $display("FAIL simul_load: got %b want 0", a2f_req_is_valid); end
        tick();
        n_cmp++; if (a2f_req_is_valid !== 1'b1 || dut_beat() !== pend[0]) begin
            n_fail++; $display("FAIL simul_first: valid %b beat %h", a2f_req_is_valid, dut_beat()); end
        void'(pend.pop_front());
        f2a_req_crd_rtn = 0;
        tick();
        n_cmp++; if (a2f_req_is_valid !== 1'b1 || dut_beat() !== pend[0]) begin
            n_fail++; $display("FAIL simul_second: valid %b beat %h", a2f_req_is_valid, dut_beat()); end
        void'(pend.pop_front());
        tick();
        n_cmp++; if ({a2f_req_is_valid, fifo_count} !== {1'b0, CW'(1)}) begin
            n_fail++; $display("FAIL simul_drained: valid/count got %b want 0/1", {a2f_req_is_valid, fifo_count}); end
    endtask

    task automatic test_disconnect_nack();
        link_down_req = 1; f2a_req_crd_rtn = 1;
        tick();
        n_cmp++; if ({conn_state, a2f_txcon_req, a2f_req_is_valid} !== 4'b11_0_0) begin
            n_fail++; $display("FAIL discon_enter: state/txcon/valid got %b want 1100", {conn_state, a2f_txcon_req, a2f_req_is_valid}); end
        link_down_req = 0; f2a_req_crd_rtn = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if ({conn_state, a2f_req_is_valid, fifo_count} !== {2'd3, 1'b0, CW'(1)}) begin
                n_fail++; $display("FAIL discon_hold: cycle %0d state/valid/count got %b", i, {conn_state, a2f_req_is_valid, fifo_count}); end
        end
        a2f_rxdiscon_nack = 1;
        tick();
        n_cmp++; if ({conn_state, a2f_txcon_req, a2f_req_is_valid} !== 4'b10_1_0) begin
            n_fail++; $display("FAIL nack_return: state/txcon/valid got %b want 1010", {conn_state, a2f_txcon_req, a2f_req_is_valid}); end
        a2f_rxdiscon_nack = 0;
        tick();
        n_cmp++; if (a2f_req_is_valid !== 1'b1 || dut_beat() !== pend[0] || fifo_count !== CW'(0)) begin
            n_fail++; $display("FAIL nack_issue: valid %b count %0d beat %h", a2f_req_is_valid, fifo_count, dut_beat()); end
        void'(pend.pop_front());
    endtask

    task automatic test_overflow();
        f2a_req_crd_rtn = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (err_crd_overflow !== (i == 4)) begin
                n_fail++; $display("FAIL overflow_flag: return %0d got %b", i, err_crd_overflow); end
        end
        f2a_req_crd_rtn = 0;
        tick();
        n_cmp++; if (err_crd_overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: got %b want 1", err_crd_overflow); end
        burst_push("ovf", 6, 4, 2);
    endtask

    task automatic test_random();
        logic [9:0] got_v, exp_v;
        for (int i = 0; i < 400; i++) begin
            drive_push(1'($urandom_range(0, 1)));
            f2a_req_crd_rtn   = ($urandom_range(0, 3) == 0);
            link_up_req       = 1;
            link_down_req     = ($urandom_range(0, 31) == 0);
            a2f_rxdiscon_nack = (m_state == 3) && ($urandom_range(0, 3) == 0);
            a2f_rxcon_ack     = (m_state == 3) ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            exp_v = {2'(m_state), (m_state == 1 || m_state == 2), m_valid, CW'(m_q.size()),
                     (m_q.size() < DEPTH), m_err};
            got_v = {conn_state, a2f_txcon_req, a2f_req_is_valid, fifo_count, req_push_ready, err_crd_overflow};
            n_cmp++; if (got_v !== exp_v) begin
                n_fail++; $display("FAIL rand_ctrl: cycle %0d got %b want %b", i, got_v, exp_v); end
            n_cmp++; if (dut_beat() !== m_out) begin
                n_fail++; $display("FAIL rand_beat: cycle %0d got %h want %h", i, dut_beat(), m_out); end
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        link_up_req = 1; link_down_req = 0; a2f_rxdiscon_nack = 0; a2f_rxcon_ack = 1;
        f2a_req_crd_rtn = 1;
        for (int i = 0; i < 20 && seen < 2; i++) begin
            drive_push(1'b1);
            tick();
            if (a2f_req_is_valid === 1'b1) seen++;
        end
        n_cmp++; if (seen < 2) begin n_fail++; $display("FAIL midreset_burst: got %0d issues want 2", seen); end
        test_reset();
    endtask

    initial begin
        fm_rst = 1'b1;
        test_reset();
        test_full_fifo();
        test_reset();
        test_connect();
        test_credit_stall();
        test_simul_issue_return();
        test_disconnect_nack();
        test_overflow();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cpi_a2f_req_tx.md
# cpi_a2f_req_tx

Agent-side CPI request-layer transmitter that sits directly upstream of `fabric_manager` and drives its A2F global and request-layer inputs. It does three things:
- runs the A2F connect/disconnect handshake;
- buffers requests from the agent core in a FIFO;
- meters issue onto `a2f_req_*` with a header-credit counter replenished by fabric credit returns.

## Interface
Parameters:
- `DEPTH`, 8: request FIFO entries, power of two, minimum 2.
- `CREDITS`, 4: header credits loaded on connect; also the credit ceiling.

Ports:
- `fm_clk`, in, 1: clock.
- `fm_rst`, in, 1: reset, asynchronous, active-low.
- `link_up_req`, in, 1: core asks for a connection (level).
- `link_down_req`, in, 1: core asks for a disconnect (level).
- `a2f_txcon_req`, out, 1: connect request to fabric.
- `a2f_rxcon_ack`, in, 1: fabric connect acknowledge.
- `a2f_rxdiscon_nack`, in, 1: fabric refuses a disconnect.
- `req_push_valid`, in, 1: core request valid.
- `req_push_ready`, out, 1: FIFO can accept.
- `req_push_protocol_id`, in, 4: request protocol id.
- `req_push_header`, in, 129: request header.
- `a2f_req_is_valid`, out, 1: request beat valid.
- `a2f_req_protocol_id`, out, 4: issued protocol id.
- `a2f_req_header`, out, 129: issued header.
- `f2a_req_crd_rtn`, in, 1: one header credit returned per high cycle.
- `conn_state`, out, 2: FSM state; DISCON=0, CONNECTING=1, CONNECTED=2, DISCONNECTING=3.
- `fifo_count`, out, $clog2(DEPTH)+1: current occupancy.
- `err_crd_overflow`, out, 1: sticky; set when a credit return arrives with the counter at CREDITS.

## Operation
- **Reset values.** All outputs are 0. `req_push_ready` is 1. The credit counter is 0.
- **DISCON** (`a2f_txcon_req`=0): go to CONNECTING when `link_up_req`=1.
- **CONNECTING** (`a2f_txcon_req`=1):
  - On `a2f_rxcon_ack`=1, go to CONNECTED and load the credit counter with CREDITS.
  - If `link_up_req` drops first, return to DISCON.
- **CONNECTED** (`a2f_txcon_req`=1): issue is allowed. Go to DISCONNECTING when `link_down_req`=1.
- **DISCONNECTING** (`a2f_txcon_req`=0): issue is blocked.
  - `a2f_rxcon_ack`=0 moves to DISCON and clears the credit counter.
  - `a2f_rxdiscon_nack`=1 moves back to CONNECTED with credits retained. Nack takes priority if it coincides with ack falling.
- **FIFO push.** A push happens when `req_push_valid && req_push_ready`. `req_push_ready` = (`fifo_count` < DEPTH), computed from the registered count. A full FIFO does not accept a push in the same cycle as a pop. Pushes are accepted in every state. FIFO contents persist across disconnects.
- **Issue.** The condition is state==CONNECTED, FIFO non-empty, credits>0. When it holds: pop the head, register it onto `a2f_req_*`, and pulse `a2f_req_is_valid` for one cycle. At most one issue per cycle; back-to-back issue is allowed. There is no backpressure beyond credits.
- **Credit arithmetic:**
  - issue only: counter −1;
  - return only: counter +1, saturating at CREDITS;
  - issue and return in the same cycle: counter unchanged;
  - return at CREDITS with no issue: counter stays at CREDITS and `err_crd_overflow` sets. It clears only on reset.
- **Idle outputs.** When `a2f_req_is_valid`=0, `a2f_req_header` and `a2f_req_protocol_id` hold their last value.
- **Pointers.** Read and write pointers wrap modulo DEPTH.
- **Reset mid-operation.** The FIFO empties, the state goes to DISCON and the credit counter clears.

## Timing
- A push accepted at edge k makes the entry eligible for issue at edge k+1. The earliest `a2f_req_is_valid` is therefore the cycle after edge k+1 (latency 1 from acceptance).
- State transitions are registered. `a2f_txcon_req` changes on the edge that enters the new state.
- An ack sampled at edge k means CONNECTED from k. The first issue can register at k+1.
- A credit return at edge k is usable for issue at edge k+1.
- `fifo_count` and `req_push_ready` update on the edge after the push or pop.

## Configuration
- `CPI_REQ_PARITY_EN` defined:
  - adds output `a2f_req_parity`, 1 bit, equal to the XOR over `{a2f_req_protocol_id, a2f_req_header}`;
  - registered alongside the beat; 0 at reset.
- `CPI_REQ_PARITY_EN` undefined: the port and its logic are absent.

## Structure
- Shared package `cpi_pkg`:
  - state enum `cpi_conn_state_e`;
  - struct `cpi_req_t` holding protocol_id[3:0] and header[128:0];
  - widths `CPI_REQ_HDR_W`=129 and `CPI_PID_W`=4.
- Sub-module `cpi_sync_fifo`, parameterised by DEPTH and element type. It holds the storage, pointers and count. The top level holds the FSM, credit counter and output register.

## Test plan
- **Connect handshake:** raise `link_up_req`; ack 3 cycles later → `conn_state` goes 0→1→2, `a2f_txcon_req`=1, credits=4.
- **Credit stall:** push 6 requests in CONNECTED with no returns → exactly 4 `a2f_req_is_valid` pulses in order and `fifo_count`=2. Then one `f2a_req_crd_rtn` pulse → a 5th issue one cycle later.
- **Full FIFO:** DISCON with DEPTH=8, push 9 → `req_push_ready`=0 after the 8th and the 9th is not accepted. Connect → 8 entries in order, 4 issued.
- **Simultaneous issue and return:** credits=1, FIFO non-empty, return on the issue cycle → counter stays 1 and the next cycle issues again.
- **Disconnect with nack:** `link_down_req` → state 3 and issue halts. Pulse `a2f_rxdiscon_nack` → back to state 2 with credits and FIFO intact.
- **Overflow and reset:** credit return at credits=4 → `err_crd_overflow`=1 and the counter stays 4. Assert `fm_rst`=0 mid-burst → all outputs 0, `fifo_count`=0, state 0.
